// File: rtl/stream_read_arbiter.sv
// Multi-channel read arbiter: grants one request per cycle onto a single memory
// port and returns in-order responses. Define STREAM_READ_ARB_RR_EN for round-robin grant.
module stream_read_arbiter #(
  parameter int NUM_CH  = 9,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  output logic [NUM_CH-1:0]        rsp_valid,
  input  logic [NUM_CH-1:0]        rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rd_start,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_done,
  output logic                     err_spurious
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0]  credits;
  logic [CNT_W-1:0]  rsp_count;
  logic [CNT_W-1:0]  in_flight;
  logic [PTR_W-1:0]  tag_wr_ptr;
  logic [PTR_W-1:0]  data_wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CH_W-1:0]   tag_mem  [MAX_OUT];
  logic [DATA_W-1:0] data_mem [MAX_OUT];

  logic              grant_any;
  logic [CH_W-1:0]   grant_idx;
  logic [ADDR_W-1:0] grant_addr;
  logic [CH_W-1:0]   tag_head;
  logic              rsp_nonempty;
  logic              accept;
  logic              pop;
  logic              rsp_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef STREAM_READ_ARB_RR_EN
  logic [CH_W-1:0] rr_ptr;

  // Two ascending passes: channels above the last grant first, then the wrap-around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && req_valid[i] && (CH_W'(i) > rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && req_valid[i] && (CH_W'(i) <= rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else if (accept) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(i);
      end
    end
  end
`endif

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Reset gates the handshake so nothing is accepted while the block is held.
  assign accept       = rst & grant_any & (credits < CREDIT_MAX);
  assign req_ready    = accept ? (NUM_CH'(1) << grant_idx) : '0;
  assign rsp_nonempty = (rsp_count != '0);
  assign tag_head     = tag_mem[rd_ptr];
  assign rsp_valid    = rsp_nonempty ? (NUM_CH'(1) << tag_head) : '0;
  assign rsp_data     = rsp_nonempty ? data_mem[rd_ptr] : '0;
  assign pop          = |(rsp_valid & rsp_ready);
  assign in_flight    = credits - rsp_count;
  assign rsp_push     = rd_done & (in_flight != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits      <= '0;
      rsp_count    <= '0;
      tag_wr_ptr   <= '0;
      data_wr_ptr  <= '0;
      rd_ptr       <= '0;
      rd_start     <= 1'b0;
      rd_addr      <= '0;
      err_spurious <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      rd_start <= accept;
      if (accept) begin
        rd_addr    <= grant_addr;
        tag_wr_ptr <= next_ptr(tag_wr_ptr);
      end
      if (rsp_push) data_wr_ptr <= next_ptr(data_wr_ptr);
      if (pop)      rd_ptr      <= next_ptr(rd_ptr);

      case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase

      case ({rsp_push, pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase

      if (rd_done && (in_flight == '0)) err_spurious <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the counters and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (accept)   tag_mem[tag_wr_ptr]   <= grant_idx;
    if (rsp_push) data_mem[data_wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_stream_read_arbiter.sv
// Directed self-checking bench for stream_read_arbiter with a request/response scoreboard.
module tb_stream_read_arbiter;

  localparam int NUM_CH  = 9;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 128;
  localparam int MAX_OUT = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [NUM_CH-1:0]        rsp_ready = '0;
  logic [DATA_W-1:0]        rsp_data;
  logic                     rd_start;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data = '0;
  logic                     rd_done = 1'b0;
  logic                     err_spurious;

  stream_read_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              exp_q[$];
  int                iss_q[$];
  logic [ADDR_W-1:0] addr_tab [NUM_CH];
  logic [DATA_W-1:0] next_data = 128'hA5;
  int                exp_order [6];
  int                errors = 0;
  int                checks = 0;
  int                accepts;

  function automatic logic [NUM_CH-1:0] oh(input int ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model and response scoreboard; called once per cycle after inputs settle.
  task automatic service();
    rsp_t e;
    int   ch;
    if ((rsp_valid & rsp_ready) != '0) begin
      if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("rsp_valid", rsp_valid, oh(e.ch));
        check("rsp_data", rsp_data, e.data);
      end
    end
    rd_done = 1'b0;
    if (rd_start === 1'b1) begin
      if (iss_q.size() == 0) check("rd_start_unexpected", rd_start, 0);
      else begin
        ch = iss_q.pop_front();
        check("rd_addr", rd_addr, addr_tab[ch]);
        rd_done = 1'b1;
        rd_data = next_data;
        e.ch    = ch;
        e.data  = next_data;
        exp_q.push_back(e);
        next_data = next_data + 1;
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    rsp_ready = '1;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && budget > 0) begin
      #1;
      service();
      tick();
      budget--;
    end
    rd_done   = 1'b0;
    rsp_ready = '0;
    check("drain_done", exp_q.size() + iss_q.size(), 0);
    #1;
    check("drain_rsp_valid", rsp_valid, 0);
  endtask

  task automatic reset_dut();
    rst       = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    rd_done   = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rd_start", rd_start, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", err_spurious, 0);
    repeat (2) tick();
    check("rst_hold_req_ready", req_ready, 0);
    req_valid = '0;
    rsp_ready = '0;
    iss_q.delete();
    exp_q.delete();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) addr_tab[i] = 32'h1000 + 32'(i) * 32'h10;
    addr_tab[3] = 32'h100;
    addr_tab[2] = 32'h200;
    addr_tab[7] = 32'h700;
    for (int i = 0; i < NUM_CH; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
`ifdef STREAM_READ_ARB_RR_EN
    exp_order = '{1, 5, 8, 1, 5, 8};
`else
    exp_order = '{1, 1, 1, 1, 1, 1};
`endif

    #2;
    reset_dut();

    // Single read on ch3: grant, strobe next cycle, response one cycle after rd_done.
    req_valid = oh(3);
    #1;
    check("t1_req_ready", req_ready, oh(3));
    iss_q.push_back(3);
    service();
    tick();
    req_valid = '0;
    #1;
    check("t1_rd_start", rd_start, 1);
    check("t1_req_ready_low", req_ready, 0);
    service();
    tick();
    check("t1_rsp_valid", rsp_valid, oh(3));
    check("t1_rsp_data", rsp_data, 128'hA5);
    check("t1_rd_start_low", rd_start, 0);
    check("t1_rd_addr_hold", rd_addr, 32'h100);
    service();
    tick();
    drain();

    // Credit limit: ch0 held valid with responses left unpopped.
    accepts   = 0;
    req_valid = oh(0);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready[0]) begin
        accepts++;
        iss_q.push_back(0);
      end
      service();
      tick();
    end
    check("t2_accepts", accepts, MAX_OUT);
    #1;
    check("t2_stalled", req_ready, 0);
    rsp_ready = oh(0);
    #1;
    check("t2_stalled_during_pop", req_ready, 0);
    service();
    tick();
    rsp_ready = '0;
    #1;
    check("t2_reopened", req_ready, oh(0));
    iss_q.push_back(0);
    service();
    tick();
    req_valid = '0;
    drain();

    // Arbitration among ch1, ch5, ch8 with immediate completion and pop.
    req_valid = oh(1) | oh(5) | oh(8);
    rsp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_grant", req_ready, oh(exp_order[k]));
      iss_q.push_back(exp_order[k]);
      service();
      tick();
    end
    req_valid = '0;
    drain();

    // Ordering: ch2 issues A, ch7 issues B, ch7 ready early must not skip ahead.
    rsp_ready = oh(7);
    req_valid = oh(2);
    #1;
    check("t4_grant_a", req_ready, oh(2));
    iss_q.push_back(2);
    service();
    tick();
    req_valid = oh(7);
    #1;
    check("t4_grant_b", req_ready, oh(7));
    iss_q.push_back(7);
    service();
    tick();
    req_valid = '0;
    #1;
    check("t4_head_a", rsp_valid, oh(2));
    service();
    tick();
    check("t4_head_a_held", rsp_valid, oh(2));
    service();
    tick();
    rsp_ready = oh(7) | oh(2);
    #1;
    service();
    tick();
    check("t4_head_b", rsp_valid, oh(7));
    service();
    tick();
    drain();

    // Spurious completion with nothing outstanding.
    check("t5_err_clear", err_spurious, 0);
    rd_data = 128'hDEAD;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("t5_err_set", err_spurious, 1);
    check("t5_no_rsp", rsp_valid, 0);
    tick();
    check("t5_err_sticky", err_spurious, 1);
    check("t5_no_rsp_late", rsp_valid, 0);

    reset_dut();
    check("t6_err_cleared", err_spurious, 0);

    // Two reads in flight, then reset; late completions must be flagged.
    req_valid = oh(4);
    #1;
    check("t6_grant_4", req_ready, oh(4));
    tick();
    req_valid = oh(6);
    #1;
    check("t6_grant_6", req_ready, oh(6));
    tick();
    req_valid = '0;
    check("t6_rd_addr", rd_addr, addr_tab[6]);
    reset_dut();
    rd_data = 128'hBEEF;
    rd_done = 1'b1;
    repeat (2) tick();
    rd_done = 1'b0;
    check("t6_late_err", err_spurious, 1);
    check("t6_late_no_rsp", rsp_valid, 0);
    req_valid = oh(4);
    #1;
    check("t6_credits_freed", req_ready, oh(4));
    tick();
    req_valid = '0;
    check("t6_post_rd_start", rd_start, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_read_arbiter.md
STREAM_READ_ARBITER -- requirements
Module: stream_read_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 9, giving the number of requester channels (2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the read address width.
REQ-003 The block SHALL have parameter DATA_W, default 128, giving the read data width.
REQ-004 The block SHALL have parameter MAX_OUT, default 4, giving the maximum number of outstanding reads (power of 2, 1..16).
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, NUM_CH bits: per-channel read request valid.
REQ-008 The block SHALL have port req_ready, output, NUM_CH bits: per-channel request accept.
REQ-009 The block SHALL have port req_addr, input, NUM_CH*ADDR_W bits: per-channel addresses, with channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port rsp_valid, output, NUM_CH bits: per-channel response valid.
REQ-011 The block SHALL have port rsp_ready, input, NUM_CH bits: per-channel response accept.
REQ-012 The block SHALL have port rsp_data, output, DATA_W bits: response data, broadcast to all channels.
REQ-013 The block SHALL have port rd_start, output, 1 bit: memory read strobe, one cycle.
REQ-014 The block SHALL have port rd_addr, output, ADDR_W bits: memory read address.
REQ-015 The block SHALL have port rd_data, input, DATA_W bits: memory read data, valid while rd_done is high.
REQ-016 The block SHALL have port rd_done, input, 1 bit: memory completion pulse; completions arrive in issue order.
REQ-017 The block SHALL have port err_spurious, output, 1 bit: sticky flag set by an unexpected rd_done.

Function
REQ-018 The block SHALL accept at most one request per cycle: req_ready[g] is high only for the granted channel g, and only when req_valid[g] is high and credits < MAX_OUT.
REQ-019 Credits SHALL count reads that have been accepted but whose response has not yet been popped; the counter is $clog2(MAX_OUT+1) bits wide.
REQ-020 When channel g is accepted in cycle N, in cycle N+1 the block SHALL drive rd_start=1 for exactly one cycle, rd_addr = the address of g registered at cycle N, and push g into the tag FIFO (depth MAX_OUT).
REQ-021 rd_addr SHALL hold its value between strobes.
REQ-022 On rd_done=1, if issued-but-not-completed > 0, the block SHALL push rd_data into the response FIFO (depth MAX_OUT); overflow cannot occur because of the credit limit.
REQ-023 On rd_done=1 with issued-but-not-completed = 0, the block SHALL drop the data and set err_spurious=1; err_spurious is cleared only by reset.
REQ-024 While the response FIFO is non-empty, the block SHALL drive rsp_data = the FIFO head and rsp_valid = one-hot of the tag FIFO head; otherwise rsp_valid = 0.
REQ-025 A pop SHALL occur when rsp_valid[t] & rsp_ready[t]; the pop removes the head data and head tag and frees one credit. rsp_ready on non-addressed channels SHALL be ignored.
REQ-026 Accept and pop in the same cycle SHALL leave credits unchanged; rd_done and pop in the same cycle SHALL be legal, including when the FIFO is empty, in which case the data appears the next cycle.
REQ-027 Response latency from rd_done to rsp_valid SHALL be 1 cycle when the response FIFO is empty.
REQ-028 A channel SHALL receive responses in the order of its requests; the global response order SHALL equal the issue order.
REQ-029 Every FIFO pointer SHALL wrap modulo MAX_OUT.

Reset
REQ-030 While rst=0, the block SHALL hold credits=0, both FIFOs empty, rd_start=0, rd_addr=0, rsp_valid=0, rsp_data=0, req_ready=0, err_spurious=0, and RR pointer = NUM_CH-1.
REQ-031 A reset during operation SHALL discard all in-flight state; a rd_done that arrives after the reset releases SHALL be treated per REQ-023.

Configuration
REQ-032 With macro STREAM_READ_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the last granted channel + 1, wraps at NUM_CH, and the pointer updates only on accept.
REQ-033 Without STREAM_READ_ARB_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and the block SHALL contain no pointer register.

Verification (NUM_CH=9, ADDR_W=32, DATA_W=128, MAX_OUT=4)
REQ-034 Single read: ch3 requests addr 0x100 -> req_ready[3] for one cycle; rd_start with rd_addr=0x100 the next cycle; rd_done with data 0xA5 -> rsp_valid[3]=1, rsp_data=0xA5 after 1 cycle.
REQ-035 Credit limit: ch0 is held valid, rsp_ready=0, and memory completes each read -> exactly 4 accepts, then req_ready=0 until one response is popped.
REQ-036 Arbitration: ch1, ch5 and ch8 are held valid -> with RR_EN the grant order is 1,5,8,1...; without RR_EN it is 1,1,1....
REQ-037 Ordering: ch2 issues A then ch7 issues B, and ch7 asserts rsp_ready early -> ch2 gets A first; B is presented only after A is popped.
REQ-038 Spurious and reset: rd_done with nothing outstanding -> err_spurious=1 and no rsp_valid; rst pulsed low while 2 reads are outstanding -> all outputs return to reset values and late completions set err_spurious.
